// File: rtl/gpio_switch_debounce.sv
// Debounce conditioner for the expansion-board GPIO switch bank.
// Each channel is synchronized, qualified by a stability count, and turned into level/edge/event outputs.
module gpio_switch_debounce #(
    parameter int NUM_SW        = 9,
    parameter int STABLE_CYCLES = 3840,
    parameter int CNT_W         = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_SW-1:0] sw_raw,
    output logic [NUM_SW-1:0] sw_level,
    output logic [NUM_SW-1:0] sw_rise,
    output logic [NUM_SW-1:0] sw_fall,
    output logic              evt_valid,
    output logic [NUM_SW-1:0] evt_mask,
    input  logic              evt_ack
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [NUM_SW-1:0] sync_p0;
    logic [NUM_SW-1:0] sync_p1;
    logic [CNT_W-1:0]  cnt_p2 [NUM_SW];

    logic [CNT_W-1:0]  cnt_nxt [NUM_SW];
    logic [NUM_SW-1:0] level_nxt;
    logic [NUM_SW-1:0] rise_nxt;
    logic [NUM_SW-1:0] fall_nxt;
    logic [NUM_SW-1:0] chg_nxt;
    logic [NUM_SW-1:0] mask_nxt;

    // The counter is cleared at CNT_LAST, so the increment can never wrap.
    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt);
        return cnt + CNT_W'(1);
    endfunction

    always_comb begin
        level_nxt = sw_level;
        rise_nxt  = '0;
        fall_nxt  = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            cnt_nxt[i] = '0;
            if (sync_p1[i] != sw_level[i]) begin
                if (cnt_p2[i] == CNT_LAST) begin
                    level_nxt[i] = sync_p1[i];
                    rise_nxt[i]  = sync_p1[i];
                    fall_nxt[i]  = ~sync_p1[i];
                end else begin
                    cnt_nxt[i] = cnt_step(cnt_p2[i]);
                end
            end
        end
        chg_nxt  = rise_nxt | fall_nxt;
        // An ack drops what was pending but keeps whatever changes on this same edge.
        mask_nxt = evt_ack ? chg_nxt : (evt_mask | chg_nxt);
    end

    // Stage p0/p1: two-flop synchronizer; stage p2: debounce count, level, pulses, event.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0   <= '0;
            sync_p1   <= '0;
            sw_level  <= '0;
            sw_rise   <= '0;
            sw_fall   <= '0;
            evt_mask  <= '0;
            evt_valid <= 1'b0;
            for (int i = 0; i < NUM_SW; i++) begin
                cnt_p2[i] <= '0;
            end
        end else begin
            sync_p0   <= sw_raw;
            sync_p1   <= sync_p0;
            sw_level  <= level_nxt;
            sw_rise   <= rise_nxt;
            sw_fall   <= fall_nxt;
            evt_mask  <= mask_nxt;
            evt_valid <= |mask_nxt;
            for (int i = 0; i < NUM_SW; i++) begin
                cnt_p2[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_gpio_switch_debounce.sv
// Bench for gpio_switch_debounce: directed scenarios on a 4-cycle instance and
// randomized traffic on 4-cycle and 1-cycle instances against a window-based reference model.
module tb_gpio_switch_debounce;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] raw4, raw1;
    logic       ack4, ack1;
    logic [8:0] lvl4, rise4, fall4, mask4;
    logic [8:0] lvl1, rise1, fall1, mask1;
    logic       valid4, valid1;

    int checks = 0;
    int errors = 0;

    // Reference model: a channel flips when its last S synchronized samples all disagree with its level.
    logic [8:0] m_p0   [2];
    logic [8:0] m_p1   [2];
    logic [8:0] m_hist [2][4];
    logic [8:0] m_level[2];
    logic [8:0] m_rise [2];
    logic [8:0] m_fall [2];
    logic [8:0] m_mask [2];
    logic       m_valid[2];

    always #5 clk = ~clk;

    gpio_switch_debounce #(.NUM_SW(9), .STABLE_CYCLES(4), .CNT_W(3)) dut4 (
        .clk(clk), .reset(reset), .sw_raw(raw4), .sw_level(lvl4), .sw_rise(rise4),
        .sw_fall(fall4), .evt_valid(valid4), .evt_mask(mask4), .evt_ack(ack4)
    );

    gpio_switch_debounce #(.NUM_SW(9), .STABLE_CYCLES(1), .CNT_W(1)) dut1 (
        .clk(clk), .reset(reset), .sw_raw(raw1), .sw_level(lvl1), .sw_rise(rise1),
        .sw_fall(fall1), .evt_valid(valid1), .evt_mask(mask1), .evt_ack(ack1)
    );

    task automatic model_edge(input int d, input int s, input logic [8:0] r,
                              input logic a, input logic rst);
        logic [8:0] flip;
        if (rst) begin
            m_p0[d] = '0;
            m_p1[d] = '0;
            for (int k = 0; k < 4; k++) m_hist[d][k] = '0;
            m_level[d] = '0;
            m_rise[d]  = '0;
            m_fall[d]  = '0;
            m_mask[d]  = '0;
            m_valid[d] = 1'b0;
        end else begin
            for (int k = 3; k > 0; k--) m_hist[d][k] = m_hist[d][k-1];
            m_hist[d][0] = m_p1[d];
            flip = '1;
            for (int k = 0; k < s; k++) flip = flip & (m_hist[d][k] ^ m_level[d]);
            m_level[d] = m_level[d] ^ flip;
            m_rise[d]  = flip & m_level[d];
            m_fall[d]  = flip & ~m_level[d];
            m_mask[d]  = a ? flip : (m_mask[d] | flip);
            m_valid[d] = |m_mask[d];
            m_p1[d] = m_p0[d];
            m_p0[d] = r;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0, 4, raw4, ack4, reset);
        model_edge(1, 1, raw1, ack1, reset);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; raw4 = '0; raw1 = '0; ack4 = 1'b0; ack1 = 1'b0;
        tick(); tick();
        checks++; if (lvl4 !== 9'h0)   begin errors++; $display("FAIL reset_level got %h exp 000", lvl4); end
        checks++; if (rise4 !== 9'h0)  begin errors++; $display("FAIL reset_rise got %h exp 000", rise4); end
        checks++; if (fall4 !== 9'h0)  begin errors++; $display("FAIL reset_fall got %h exp 000", fall4); end
        checks++; if (mask4 !== 9'h0)  begin errors++; $display("FAIL reset_mask got %h exp 000", mask4); end
        checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid4); end
        checks++; if ({lvl1, rise1, fall1, mask1, valid1} !== 37'h0)
            begin errors++; $display("FAIL reset_dut1 got %h exp 0", {lvl1, rise1, fall1, mask1, valid1}); end
        reset = 1'b0;
    endtask

    task automatic test_single_rise();
        raw4[0] = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            checks++; if (lvl4[0] !== (n >= 6))
                begin errors++; $display("FAIL rise_level n=%0d got %b exp %b", n, lvl4[0], n >= 6); end
            checks++; if (rise4[0] !== (n == 6))
                begin errors++; $display("FAIL rise_pulse n=%0d got %b exp %b", n, rise4[0], n == 6); end
        end
        checks++; if (mask4 !== 9'h001 || valid4 !== 1'b1)
            begin errors++; $display("FAIL rise_evt got %h/%b exp 001/1", mask4, valid4); end
    endtask

    task automatic test_bounce();
        int rises = 0;
        for (int c = 0; c < 20; c++) begin
            raw4[3] = ((c / 2) % 2) == 0;
            tick();
            if (rise4[3] === 1'b1) rises++;
            checks++; if (lvl4[3] !== 1'b0)
                begin errors++; $display("FAIL bounce_level c=%0d got %b exp 0", c, lvl4[3]); end
        end
        raw4[3] = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (rise4[3] === 1'b1) rises++;
            checks++; if (rise4[3] !== (n == 6))
                begin errors++; $display("FAIL bounce_pulse n=%0d got %b exp %b", n, rise4[3], n == 6); end
        end
        checks++; if (rises != 1) begin errors++; $display("FAIL bounce_count got %0d exp 1", rises); end
    endtask

    task automatic test_evt_mask();
        raw4[8] = 1'b1;
        repeat (7) tick();
        ack4 = 1'b1; tick(); ack4 = 1'b0;
        checks++; if (mask4 !== 9'h000 || valid4 !== 1'b0)
            begin errors++; $display("FAIL evt_clear got %h/%b exp 000/0", mask4, valid4); end
        raw4[0] = 1'b0; raw4[2] = 1'b1;
        repeat (6) tick();
        checks++; if (fall4[0] !== 1'b1 || rise4[2] !== 1'b1)
            begin errors++; $display("FAIL evt_pulses got %b%b exp 11", fall4[0], rise4[2]); end
        checks++; if (mask4 !== 9'b000000101 || valid4 !== 1'b1)
            begin errors++; $display("FAIL evt_two got %b/%b exp 000000101/1", mask4, valid4); end
        raw4[8] = 1'b0;
        repeat (6) tick();
        checks++; if (fall4[8] !== 1'b1)
            begin errors++; $display("FAIL evt_ch8_fall got %b exp 1", fall4[8]); end
        checks++; if (mask4 !== 9'b100000101 || valid4 !== 1'b1)
            begin errors++; $display("FAIL evt_accum got %b/%b exp 100000101/1", mask4, valid4); end
    endtask

    task automatic test_ack_same_edge();
        raw4[1] = 1'b1;
        repeat (5) tick();
        ack4 = 1'b1; tick();
        checks++; if (mask4 !== 9'b000000010 || valid4 !== 1'b1 || rise4[1] !== 1'b1)
            begin errors++; $display("FAIL ack_same got %b/%b/%b exp 000000010/1/1", mask4, valid4, rise4[1]); end
        tick();
        checks++; if (mask4 !== 9'h000 || valid4 !== 1'b0)
            begin errors++; $display("FAIL ack_clear got %h/%b exp 000/0", mask4, valid4); end
        tick();
        ack4 = 1'b0; tick();
        checks++; if (mask4 !== 9'h000 || valid4 !== 1'b0)
            begin errors++; $display("FAIL ack_idle got %h/%b exp 000/0", mask4, valid4); end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; raw4 = '0; tick(); reset = 1'b0; tick();
        raw4[5] = 1'b1;
        repeat (4) tick();
        reset = 1'b1; tick();
        checks++; if (lvl4 !== 9'h0 || rise4 !== 9'h0 || mask4 !== 9'h0 || valid4 !== 1'b0)
            begin errors++; $display("FAIL midreset_clear got %h/%h/%h/%b exp 0", lvl4, rise4, mask4, valid4); end
        reset = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            checks++; if (rise4[5] !== (n == 6) || lvl4[5] !== (n >= 6))
                begin errors++; $display("FAIL midreset_rise n=%0d got %b/%b exp %b/%b", n, rise4[5], lvl4[5], n == 6, n >= 6); end
        end
    endtask

    task automatic test_random();
        logic [8:0] rh[$];
        logic [8:0] exp_l, exp_p;
        for (int n = 1; n <= 400; n++) begin
            if ($urandom_range(0, 5) == 0) raw4[$urandom_range(0, 8)] ^= 1'b1;
            ack4 = ($urandom_range(0, 9) == 0);
            raw1 = 9'($urandom);
            ack1 = ($urandom_range(0, 3) == 0);
            rh.push_back(raw1);
            tick();
            checks++; if (lvl4 !== m_level[0] || rise4 !== m_rise[0] || fall4 !== m_fall[0])
                begin errors++; $display("FAIL rand4_lvl n=%0d got %h/%h/%h exp %h/%h/%h", n, lvl4, rise4, fall4, m_level[0], m_rise[0], m_fall[0]); end
            checks++; if (mask4 !== m_mask[0] || valid4 !== m_valid[0])
                begin errors++; $display("FAIL rand4_evt n=%0d got %h/%b exp %h/%b", n, mask4, valid4, m_mask[0], m_valid[0]); end
            checks++; if (mask1 !== m_mask[1] || valid1 !== m_valid[1])
                begin errors++; $display("FAIL rand1_evt n=%0d got %h/%b exp %h/%b", n, mask1, valid1, m_mask[1], m_valid[1]); end
            if (n >= 3) begin
                exp_l = rh[n-3];
                checks++; if (lvl1 !== exp_l)
                    begin errors++; $display("FAIL rand1_delay n=%0d got %h exp %h", n, lvl1, exp_l); end
            end
            if (n >= 4) begin
                exp_l = rh[n-3];
                exp_p = rh[n-4];
                checks++; if (rise1 !== (exp_l & ~exp_p) || fall1 !== (~exp_l & exp_p))
                    begin errors++; $display("FAIL rand1_pulse n=%0d got %h/%h exp %h/%h", n, rise1, fall1, exp_l & ~exp_p, ~exp_l & exp_p); end
            end
            checks++; if ((rise4 & fall4) !== 9'h0 || (rise1 & fall1) !== 9'h0)
                begin errors++; $display("FAIL rand_both n=%0d got %h/%h exp 0", n, rise4 & fall4, rise1 & fall1); end
        end
        ack4 = 1'b0; ack1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_rise();
        test_bounce();
        test_evt_mask();
        test_ack_same_edge();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
